// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared funct3 encodings, FSM state and decoded-op enums for alu_pipe.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } op_t;

  function automatic logic is_shift(input op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_decode
// Brief    : Combinational instruction-word to ALU operation decoder.
// Revision : 1.0 - initial release
// ============================================================================
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] I,
  output op_t         o_op
);

  logic [2:0] w_f3;
  logic       w_alt;
  logic       w_rtype;
  logic       w_unused;

  assign w_f3     = I[14:12];
  assign w_alt    = I[30];
  assign w_rtype  = I[5];
  assign w_unused = ^{I[31], I[29:15], I[11:6], I[4:0]};

  always_comb begin
    o_op = OP_ADD;
    case (w_f3)
      F3_ADD:  o_op = (w_rtype && w_alt) ? OP_SUB : OP_ADD;
      F3_SLL:  o_op = OP_SLL;
      F3_SLT:  o_op = OP_SLT;
      F3_SLTU: o_op = OP_SLTU;
      F3_XOR:  o_op = OP_XOR;
      F3_SRL:  o_op = w_alt ? OP_SRA : OP_SRL;
      F3_OR:   o_op = OP_OR;
      F3_AND:  o_op = OP_AND;
      default: o_op = OP_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Single-stage ALU with valid/ready handshakes. Define
//            ALU_SERIAL_SHIFT_EN for a 1-bit-per-cycle shifter, else barrel.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [31:0]     I,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] o,
  output logic            busy
);

  op_t             w_op;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_result;
  logic            w_slot_free;
  logic            w_accept;
  logic            w_drain;
  logic            w_load;
  logic [XLEN-1:0] w_o_nxt;

  alu_decode u_decode (
    .I    (I),
    .o_op (w_op)
  );

  assign w_shamt     = rs2[SHW-1:0];
  assign w_slot_free = !out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_drain     = out_valid && out_ready;

  always_comb begin
    w_result = '0;
    case (w_op)
      OP_ADD:  w_result = rs1 + rs2;
      OP_SUB:  w_result = rs1 - rs2;
      OP_SLL:  w_result = rs1 << w_shamt;
      OP_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      OP_SLTU: w_result = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      OP_XOR:  w_result = rs1 ^ rs2;
      OP_SRL:  w_result = rs1 >> w_shamt;
      OP_SRA:  w_result = $signed(rs1) >>> w_shamt;
      OP_OR:   w_result = rs1 | rs2;
      OP_AND:  w_result = rs1 & rs2;
      default: w_result = '0;
    endcase
  end

`ifdef ALU_SERIAL_SHIFT_EN
  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_work;
  logic [XLEN-1:0] w_work_nxt;
  logic [SHW-1:0]  r_count;
  logic [SHW-1:0]  w_count_nxt;
  op_t             r_sop;
  op_t             w_sop_nxt;

  function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v, input op_t op);
    case (op)
      OP_SLL:  return {v[XLEN-2:0], 1'b0};
      OP_SRA:  return {v[XLEN-1], v[XLEN-1:1]};
      default: return {1'b0, v[XLEN-1:1]};
    endcase
  endfunction

  assign in_ready = !rst && (r_state == ST_IDLE) && w_slot_free;
  assign busy     = (r_state == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_count <= '0;
      r_sop   <= OP_ADD;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_count <= w_count_nxt;
      r_sop   <= w_sop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_count_nxt = r_count;
    w_sop_nxt   = r_sop;
    w_load      = 1'b0;
    w_o_nxt     = w_result;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // Zero-amount shifts bypass the FSM and complete like any other op.
          if (is_shift(w_op) && (w_shamt != '0)) begin
            w_state_nxt = ST_SHIFT;
            w_work_nxt  = rs1;
            w_count_nxt = w_shamt;
            w_sop_nxt   = w_op;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        w_work_nxt  = shift1(r_work, r_sop);
        w_count_nxt = r_count - 1'b1;
        if (r_count == SHW'(1)) begin
          w_state_nxt = ST_IDLE;
          w_load      = 1'b1;
          w_o_nxt     = shift1(r_work, r_sop);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end
`else
  assign in_ready = !rst && w_slot_free;
  assign busy     = 1'b0;
  assign w_load   = w_accept;
  assign w_o_nxt  = w_result;
`endif

  // A serial shift can only finish with the output slot empty, because entry
  // required the slot to be free or draining on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      o         <= '0;
    end else if (w_load) begin
      out_valid <= 1'b1;
      o         <= w_o_nxt;
    end else if (w_drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Self-checking scoreboard bench for alu_pipe (XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [31:0]     I;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] o;
  logic            busy;

  logic [XLEN-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_pipe #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .I         (I),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .busy      (busy)
  );

  // Random filler in the bits the decoder must ignore.
  function automatic logic [31:0] mk_i(input logic [2:0] f3, input logic alt, input logic r);
    logic [31:0] v;
    v = $urandom & 32'hBFFF_8FDF;
    v[30]    = alt;
    v[14:12] = f3;
    v[5]     = r;
    return v;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]         sh;
    logic signed [31:0] sa;
    sh = b[4:0];
    sa = a;
    case (ins[14:12])
      3'b000:  return (ins[5] && ins[30]) ? a - b : a + b;
      3'b001:  return a << sh;
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b101:  return ins[30] ? 32'(sa >>> sh) : a >> sh;
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rs1 = '0; rs2 = '0; I = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (o !== 32'h0) $display("FAIL reset_o got %h want 0", o); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_arith;
    logic [2:0]  f3 [11] = '{3'b000, 3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111, 3'b001, 3'b101, 3'b000, 3'b010};
    logic        alt[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        rt [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] va [11] = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hA5A5_0000,
                             32'hA5A5_A5A5, 32'h1234_5678, 32'h8765_4321, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] vb [11] = '{32'd7, 32'd7, 32'd1, 32'd1, 32'h0F0F_0F0F, 32'h0000_5A5A,
                             32'h0F0F_0F0F, 32'hFFFF_FFE0, 32'h0000_0040, 32'd2, 32'hFFFF_FFFF};
    logic [31:0] want;
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      I = mk_i(f3[i], alt[i], rt[i]); rs1 = va[i]; rs2 = vb[i]; in_valid = 1'b1;
      #1;
      n_total++; if (in_ready !== 1'b1) $display("FAIL arith_in_ready[%0d] got %b want 1", i, in_ready); else n_pass++;
      exp_q.push_back(model(I, rs1, rs2));
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
      want = exp_q.pop_front();
      n_total++; if (out_valid !== 1'b1) $display("FAIL arith_valid[%0d] got %b want 1", i, out_valid); else n_pass++;
      n_total++; if (n !== 0) $display("FAIL arith_latency[%0d] got %0d extra cycles want 0", i, n); else n_pass++;
      n_total++; if (o !== want) $display("FAIL arith_o[%0d] got %h want %h", i, o, want); else n_pass++;
    end
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL arith_drain got out_valid=%b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_shifts;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] want;
    int          sh;
    int          n;
    int          lat;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      f3  = (i % 3 == 0) ? 3'b001 : 3'b101;
      alt = (i % 3 == 2);
      sh  = $urandom_range(31, 1);
      I = mk_i(f3, alt, i[0]); rs1 = $urandom | 32'h8000_0001; rs2 = ($urandom & 32'hFFFF_FFE0) | 32'(sh);
      in_valid = 1'b1;
      #1;
      exp_q.push_back(model(I, rs1, rs2));
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
`ifdef ALU_SERIAL_SHIFT_EN
      lat = sh;
`else
      lat = 0;
`endif
      want = exp_q.pop_front();
      n_total++; if (n !== lat) $display("FAIL shift_latency[%0d] got %0d want %0d", i, n, lat); else n_pass++;
      n_total++; if (o !== want) $display("FAIL shift_o[%0d] got %h want %h", i, o, want); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sra_serial;
    int n;
    int bcnt;
    int bad;
    int want_busy;
    logic [31:0] want;
`ifdef ALU_SERIAL_SHIFT_EN
    want_busy = 4;
`else
    want_busy = 0;
`endif
    out_ready = 1'b1;
    I = mk_i(3'b101, 1'b1, 1'b0); rs1 = 32'h8000_0000; rs2 = 32'h0000_0024; in_valid = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL sra_in_ready_accept got %b want 1", in_ready); else n_pass++;
    exp_q.push_back(32'hF800_0000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0; bcnt = 0; bad = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      if (busy === 1'b1) bcnt++;
      if (in_ready !== 1'b0) bad++;
      @(posedge clk); #1; n++;
    end
    want = exp_q.pop_front();
    n_total++; if (bcnt !== want_busy) $display("FAIL sra_busy_cycles got %0d want %0d", bcnt, want_busy); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL sra_in_ready_while_busy got %0d cycles high want 0", bad); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL sra_busy_after got %b want 0", busy); else n_pass++;
    n_total++; if (o !== want) $display("FAIL sra_o got %h want %h", o, want); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] want_a;
    logic [31:0] want;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      I = mk_i(3'b000, 1'b0, 1'b1); rs1 = $urandom; rs2 = $urandom; in_valid = 1'b1;
      #1;
      n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d] got %b want 1", k, in_ready); else n_pass++;
      exp_q.push_back(rs1 + rs2);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b want 1", k, out_valid); else n_pass++;
      n_total++; if (o !== want) $display("FAIL b2b_o[%0d] got %h want %h", k, o, want); else n_pass++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    I = mk_i(3'b000, 1'b0, 1'b1); rs1 = 32'h0000_1000; rs2 = 32'h0000_0234; in_valid = 1'b1;
    exp_q.push_back(32'h0000_1234);
    @(posedge clk); #1;
    want_a = exp_q.pop_front();
    n_total++; if (o !== want_a) $display("FAIL stall_first_o got %h want %h", o, want_a); else n_pass++;
    rs1 = 32'h0000_2000; rs2 = 32'h0000_0345;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (o !== want_a || out_valid !== 1'b1) $display("FAIL stall_hold got o=%h v=%b want o=%h v=1", o, out_valid, want_a); else n_pass++;
    out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL stall_release_in_ready got %b want 1", in_ready); else n_pass++;
    exp_q.push_back(32'h0000_2345);
    @(posedge clk); #1;
    in_valid = 1'b0;
    want = exp_q.pop_front();
    n_total++; if (o !== want || out_valid !== 1'b1) $display("FAIL stall_second_o got o=%h v=%b want o=%h v=1", o, out_valid, want); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift;
    int seen;
    out_ready = 1'b0;
    I = mk_i(3'b001, 1'b0, 1'b1); rs1 = 32'h0000_0003; rs2 = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready got %b want 0", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else n_pass++;
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen++; end
    n_total++; if (seen !== 0) $display("FAIL rst_mid_no_result got %0d valid cycles want 0", seen); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_shifts();
    test_sra_serial();
    test_back_to_back();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
